xor_table_lookup_reader: RTL and testbench
==========================================

# xor_table_lookup_reader

Read-side pipeline for the XOR-coded multi-port hash table. It accepts one lookup per cycle and issues the read address to the NUM_WR bank copies belonging to this read port. It XORs the returned slices to recover the stored entry, applies forwarding from writes still in flight, and reports hit/miss with the stored value. It is the counterpart to the write-side XOR pipeline and uses the same entry format: bit KEY_WIDTH+VALUE_WIDTH = valid, then value, then key in the LSBs.

## Interface
- NUM_WR, 8, number of write ports, which equals the number of bank copies XORed per read
- INDEX_WIDTH, 12, table address width
- VALUE_WIDTH, 31, value field width
- KEY_WIDTH, 32, key field width
- DATA_WIDTH, 64, entry width; must be ≥ KEY_WIDTH+VALUE_WIDTH+1
- RD_LATENCY, 2, bank read latency in cycles, ≥1
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- en_in  in  1  request strobe
- opt_in  in  2  operation code; 00 = read. Any other code is ignored by this block.
- index_in  in  INDEX_WIDTH  lookup address
- key_in  in  KEY_WIDTH  lookup key
- rd_en  out  1  bank read enable, registered
- rd_addr  out  INDEX_WIDTH  bank read address, registered
- rd_bank_data  in  NUM_WR*DATA_WIDTH  bank slices; slice j is bank j
- wr_snoop_valid  in  NUM_WR  write port j commits this cycle
- wr_snoop_index  in  NUM_WR*INDEX_WIDTH  commit address per port
- wr_snoop_entry  in  NUM_WR*DATA_WIDTH  plain (un-XORed) entry per port
- out_valid  out  1  result strobe
- out_hit  out  1  key found and entry valid
- out_value  out  VALUE_WIDTH  stored value; 0 on miss
- out_key  out  KEY_WIDTH  echoed lookup key
- out_index  out  INDEX_WIDTH  echoed lookup index

## Operation
- A lookup is accepted in cycle c when en_in=1 and opt_in=00. The block has no backpressure and accepts one lookup per cycle.
- Cycle c+1: rd_en=1 and rd_addr=index. The key and index are carried down a valid-tagged shift pipeline of depth RD_LATENCY+1.
- Cycle c+1+RD_LATENCY: rd_bank_data holds the bank state, which reflects every snoop committed in cycles ≤ c.
- Decode: raw = XOR of all NUM_WR slices.
- Forwarding: each in-flight lookup holds fwd_v and fwd_entry.
  - The capture window is cycles c+1 through c+1+RD_LATENCY inclusive.
  - In each window cycle, any port j with wr_snoop_valid[j]=1 and a matching index overwrites fwd_entry. A later cycle overrides an earlier one.
  - Among simultaneous matching ports, the highest j wins.
- Final entry = fwd_v ? fwd_entry : raw.
- hit = entry[KEY_WIDTH+VALUE_WIDTH] & (entry[KEY_WIDTH-1:0] == key).
- out_value = hit ? entry value field : 0.
- Bits above KEY_WIDTH+VALUE_WIDTH are ignored.
- Writes (01), deletes (11) and code 10 produce no rd_en and no output.

## Timing
- Latency: request in cycle c gives out_valid=1 in cycle c+2+RD_LATENCY, which is 4 cycles at the default.
- Results are produced in request order, with one out_valid pulse per accepted lookup.
- All outputs are registered.
- Reset values: rd_en=0, rd_addr=0, out_valid=0, out_hit=0, out_value=0, out_key=0, out_index=0. All pipeline valid and fwd_v bits are cleared.
- Reset mid-operation drops every in-flight lookup. out_valid stays 0 until a lookup accepted after reset deasserts completes its full latency.
- A request in the same cycle reset is high is discarded.
- Boundary rule for snoops: a snoop in cycle c (the request cycle) is not forwarded, because the banks already reflect it. A snoop in cycle c+1+RD_LATENCY is forwarded.
- Back-to-back lookups to the same index each see only the snoops inside their own window.

## Test plan
- Reset, then idle for 10 cycles -> all outputs 0; rd_en never asserts.
- Banks preloaded so that the slice XOR = {1, value 0x1234, key 0xCAFE} at index 5; read index 5 with key 0xCAFE in cycle 0 -> rd_en/rd_addr=5 in cycle 1; out_valid, out_hit=1, out_value=0x1234 in cycle 4.
- Same setup with key 0xBEEF -> out_hit=0, out_value=0. Entry with valid bit 0 and key 0xCAFE -> out_hit=0.
- Read index 5 in cycle 0:
  - Port 3 snoops index 5, entry {1, 0x77, 0xCAFE} in cycle 3 -> cycle 4 out_value=0x77.
  - Same snoop in cycle 0 -> bank data is used.
  - Ports 2 and 6 both snoop in cycle 2 -> port 6's entry is used.
- Reads in cycles 0–7 to indices 0–7 -> out_valid high in cycles 4–11, with out_index 0–7 in order.
- Reads in cycles 0–2, reset in cycle 3 -> no out_valid in cycles 4–6. A read in cycle 5 returns in cycle 9.

Source files
------------

// File: rtl/xor_table_lookup_reader.sv
// Read side of the XOR-coded multi-port hash table: issues bank reads, XOR-decodes
// the returned slices, forwards in-flight writes and reports hit/miss per lookup.
module xor_table_lookup_reader #(
    parameter int NUM_WR      = 8,
    parameter int INDEX_WIDTH = 12,
    parameter int VALUE_WIDTH = 31,
    parameter int KEY_WIDTH   = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int RD_LATENCY  = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en_in,
    input  logic [1:0]                    opt_in,
    input  logic [INDEX_WIDTH-1:0]        index_in,
    input  logic [KEY_WIDTH-1:0]          key_in,
    output logic                          rd_en,
    output logic [INDEX_WIDTH-1:0]        rd_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0]  rd_bank_data,
    input  logic [NUM_WR-1:0]             wr_snoop_valid,
    input  logic [NUM_WR*INDEX_WIDTH-1:0] wr_snoop_index,
    input  logic [NUM_WR*DATA_WIDTH-1:0]  wr_snoop_entry,
    output logic                          out_valid,
    output logic                          out_hit,
    output logic [VALUE_WIDTH-1:0]        out_value,
    output logic [KEY_WIDTH-1:0]          out_key,
    output logic [INDEX_WIDTH-1:0]        out_index
);

    localparam int VALID_BIT = KEY_WIDTH + VALUE_WIDTH;
    localparam int ENTRY_W   = VALID_BIT + 1;
    localparam int DEPTH     = RD_LATENCY + 1;

    typedef struct packed {
        logic                   valid;
        logic [KEY_WIDTH-1:0]   key;
        logic [INDEX_WIDTH-1:0] index;
        logic                   fwd_v;
        logic [ENTRY_W-1:0]     fwd_entry;
    } stage_t;

    stage_t             pipe     [DEPTH];
    stage_t             pipe_fwd [DEPTH];
    stage_t             last;
    logic [ENTRY_W-1:0] raw;
    logic [ENTRY_W-1:0] entry;
    logic               accept;
    logic               hit;

    assign accept = en_in && (opt_in == 2'b00);

    // Every stage is inside its capture window, so each one snoops every cycle;
    // ascending port order lets the highest matching port win.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            // NOTE: each stage starts from its registered value so no path leaves it unassigned (no latch).
            pipe_fwd[k] = pipe[k];
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_snoop_valid[j] &&
                    wr_snoop_index[j*INDEX_WIDTH +: INDEX_WIDTH] == pipe[k].index) begin
                    pipe_fwd[k].fwd_v     = 1'b1;
                    pipe_fwd[k].fwd_entry = wr_snoop_entry[j*DATA_WIDTH +: ENTRY_W];
                end
            end
        end
    end

    always_comb begin
        raw = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            raw ^= rd_bank_data[j*DATA_WIDTH +: ENTRY_W];
        end
    end

    assign last  = pipe_fwd[DEPTH-1];
    assign entry = last.fwd_v ? last.fwd_entry : raw;
    assign hit   = entry[VALID_BIT] && (entry[KEY_WIDTH-1:0] == last.key);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            out_valid <= 1'b0;
            out_hit   <= 1'b0;
            out_value <= '0;
            out_key   <= '0;
            out_index <= '0;
            // NOTE: the pipeline is a handful of flops, not a RAM, so clearing it on reset is cheap and drops in-flight lookups.
            for (int k = 0; k < DEPTH; k++) begin
                pipe[k] <= '0;
            end
        end else begin
            rd_en <= accept;
            if (accept) begin
                rd_addr <= index_in;
            end

            // A snoop in the request cycle is already in the banks, so stage 0 starts unforwarded.
            pipe[0] <= '{valid: accept, key: key_in, index: index_in,
                         fwd_v: 1'b0, fwd_entry: '0};
            for (int k = 1; k < DEPTH; k++) begin
                pipe[k] <= pipe_fwd[k-1];
            end

            out_valid <= last.valid;
            if (last.valid) begin
                out_hit   <= hit;
                out_value <= hit ? entry[KEY_WIDTH +: VALUE_WIDTH] : '0;
                out_key   <= last.key;
                out_index <= last.index;
            end else begin
                out_hit   <= 1'b0;
                out_value <= '0;
            end
        end
    end

endmodule

// File: tb/tb_xor_table_lookup_reader.sv
// Randomized scoreboard bench for xor_table_lookup_reader: a schedule-driven table
// model predicts each lookup, and monitors compare DUT reads and results against it.
module tb_xor_table_lookup_reader;

    localparam int NW   = 8;
    localparam int IW   = 12;
    localparam int VW   = 31;
    localparam int KW   = 32;
    localparam int DW   = 64;
    localparam int L    = 2;
    localparam int NCYC = 600;

    logic              clk = 1'b0;
    logic              reset;
    logic              en_in;
    logic [1:0]        opt_in;
    logic [IW-1:0]     index_in;
    logic [KW-1:0]     key_in;
    logic              rd_en;
    logic [IW-1:0]     rd_addr;
    logic [NW*DW-1:0]  rd_bank_data = '0;
    logic [NW-1:0]     wr_snoop_valid;
    logic [NW*IW-1:0]  wr_snoop_index;
    logic [NW*DW-1:0]  wr_snoop_entry;
    logic              out_valid;
    logic              out_hit;
    logic [VW-1:0]     out_value;
    logic [KW-1:0]     out_key;
    logic [IW-1:0]     out_index;

    xor_table_lookup_reader #(
        .NUM_WR(NW), .INDEX_WIDTH(IW), .VALUE_WIDTH(VW),
        .KEY_WIDTH(KW), .DATA_WIDTH(DW), .RD_LATENCY(L)
    ) dut (
        .clk(clk), .reset(reset), .en_in(en_in), .opt_in(opt_in),
        .index_in(index_in), .key_in(key_in), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_bank_data(rd_bank_data), .wr_snoop_valid(wr_snoop_valid),
        .wr_snoop_index(wr_snoop_index), .wr_snoop_entry(wr_snoop_entry),
        .out_valid(out_valid), .out_hit(out_hit), .out_value(out_value),
        .out_key(out_key), .out_index(out_index)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [KW-1:0] key;
        logic [IW-1:0] idx;
        logic          hit;
        logic [VW-1:0] value;
    } out_t;

    typedef struct {
        int            due;
        logic [IW-1:0] addr;
    } rd_t;

    typedef struct {
        int            due;
        logic [DW-1:0] entry;
    } bank_t;

    out_t  out_q  [$];
    rd_t   rd_q   [$];
    bank_t bank_q [$];

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = -1;

    // Whole-run schedule, filled before the clock loop starts.
    logic          s_rst  [NCYC];
    logic          s_en   [NCYC];
    logic [1:0]    s_opt  [NCYC];
    logic [IW-1:0] s_idx  [NCYC];
    logic [KW-1:0] s_key  [NCYC];
    logic          s_idle [NCYC];
    logic [NW-1:0] s_sv   [NCYC];
    logic [IW-1:0] s_sidx [NCYC][NW];
    logic [DW-1:0] s_sent [NCYC][NW];
    logic [DW-1:0] init_tbl [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic v, input logic [VW-1:0] val,
                                         input logic [KW-1:0] key);
        return {v, val, key};
    endfunction

    // Table contents at idx once every write committed in cycles 0..through has landed.
    function automatic logic [DW-1:0] table_at(input logic [IW-1:0] idx, input int through);
        logic [DW-1:0] e;
        e = (idx < 16) ? init_tbl[idx[3:0]] : '0;
        for (int t = 0; t <= through && t < NCYC; t++) begin
            for (int j = 0; j < NW; j++) begin
                if (s_sv[t][j] && s_sidx[t][j] == idx) e = s_sent[t][j];
            end
        end
        return e;
    endfunction

    function automatic logic [KW-1:0] pick_key();
        case ($urandom_range(0, 3))
            0:       return 32'hCAFE;
            1:       return 32'hBEEF;
            2:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    task automatic req(input int n, input logic [IW-1:0] idx, input logic [KW-1:0] key);
        s_en[n]  = 1'b1;
        s_opt[n] = 2'b00;
        s_idx[n] = idx;
        s_key[n] = key;
    endtask

    task automatic snoop(input int n, input int j, input logic [IW-1:0] idx, input logic [DW-1:0] e);
        s_sv[n][j]   = 1'b1;
        s_sidx[n][j] = idx;
        s_sent[n][j] = e;
    endtask

    // Monitor and bank environment, both evaluated mid-cycle.
    always @(negedge clk) begin
        if (cyc >= 0) begin
            if (out_q.size() > 0 && out_q[0].due < cyc) begin
                check("missed_out_valid", 64'(cyc), 64'(out_q[0].due));
                void'(out_q.pop_front());
            end
            if (out_valid !== 1'b0) begin
                if (out_q.size() == 0) begin
                    check("unexpected_out_valid", {63'd0, out_valid}, 64'd0);
                end else begin
                    out_t e;
                    e = out_q.pop_front();
                    check("out_cycle", 64'(cyc), 64'(e.due));
                    check("out_key", 64'(out_key), 64'(e.key));
                    check("out_index", 64'(out_index), 64'(e.idx));
                    check("out_hit", 64'(out_hit), 64'(e.hit));
                    check("out_value", 64'(out_value), 64'(e.value));
                end
            end

            if (rd_q.size() > 0 && rd_q[0].due < cyc) begin
                check("missed_rd_en", 64'(cyc), 64'(rd_q[0].due));
                void'(rd_q.pop_front());
            end
            if (rd_en !== 1'b0) begin
                if (rd_q.size() == 0) begin
                    check("unexpected_rd_en", {63'd0, rd_en}, 64'd0);
                end else begin
                    rd_t r;
                    r = rd_q.pop_front();
                    check("rd_cycle", 64'(cyc), 64'(r.due));
                    check("rd_addr", 64'(rd_addr), 64'(r.addr));
                end
            end

            if (s_idle[cyc]) begin
                check("idle_rd_en", 64'(rd_en), 64'd0);
                check("idle_rd_addr", 64'(rd_addr), 64'd0);
                check("idle_out_valid", 64'(out_valid), 64'd0);
                check("idle_out_hit", 64'(out_hit), 64'd0);
                check("idle_out_value", 64'(out_value), 64'd0);
                check("idle_out_key", 64'(out_key), 64'd0);
                check("idle_out_index", 64'(out_index), 64'd0);
            end

            // Banks answer RD_LATENCY cycles after the read with the state before it.
            if (rd_en === 1'b1) begin
                bank_q.push_back('{due: cyc + L, entry: table_at(rd_addr, cyc - 1)});
            end
            if (bank_q.size() > 0 && bank_q[0].due == cyc) begin
                logic [DW-1:0] acc;
                logic [DW-1:0] s;
                acc = bank_q.pop_front().entry;
                for (int j = 0; j < NW - 1; j++) begin
                    s = {$urandom, $urandom};
                    rd_bank_data[j*DW +: DW] = s;
                    acc ^= s;
                end
                rd_bank_data[(NW-1)*DW +: DW] = acc;
            end else begin
                for (int j = 0; j < NW; j++) begin
                    rd_bank_data[j*DW +: DW] = {$urandom, $urandom};
                end
            end
        end
    end

    initial begin
        reset = 1'b1; en_in = 1'b0; opt_in = 2'b00; index_in = '0; key_in = '0;
        wr_snoop_valid = '0; wr_snoop_index = '0; wr_snoop_entry = '0;

        for (int n = 0; n < NCYC; n++) begin
            s_rst[n] = 1'b0; s_en[n] = 1'b0; s_opt[n] = 2'b00; s_idx[n] = '0;
            s_key[n] = '0; s_idle[n] = 1'b0; s_sv[n] = '0;
            for (int j = 0; j < NW; j++) begin
                s_sidx[n][j] = '0;
                s_sent[n][j] = '0;
            end
        end
        for (int i = 0; i < 16; i++) begin
            init_tbl[i] = mk($urandom_range(0, 3) != 0, VW'($urandom), pick_key());
        end
        init_tbl[5] = mk(1'b1, 31'h1234, 32'hCAFE);
        init_tbl[6] = mk(1'b0, 31'h1234, 32'hCAFE);

        // Reset, then a quiet stretch where every output must sit at zero.
        for (int n = 0; n < 3; n++) s_rst[n] = 1'b1;
        for (int n = 3; n < 13; n++) s_idle[n] = 1'b1;

        // Stored-entry hit, key miss, invalid-entry miss.
        req(13, 5, 32'hCAFE);
        req(18, 5, 32'hBEEF);
        req(20, 6, 32'hCAFE);
        // Snoop in the last window cycle is forwarded.
        req(24, 5, 32'hCAFE);
        snoop(27, 3, 5, mk(1'b1, 31'h77, 32'hCAFE));
        // Snoop in the request cycle comes back through the banks.
        req(32, 5, 32'hCAFE);
        snoop(32, 3, 5, mk(1'b1, 31'h99, 32'hCAFE));
        // Simultaneous ports: highest wins; other-index and post-window snoops are ignored.
        req(40, 5, 32'hCAFE);
        snoop(41, 0, 7, mk(1'b1, 31'h11, 32'hCAFE));
        snoop(42, 2, 5, mk(1'b1, 31'hAA, 32'hCAFE));
        snoop(42, 6, 5, mk(1'b1, 31'hBB, 32'hCAFE));
        snoop(44, 1, 5, mk(1'b1, 31'hCC, 32'hCAFE));
        // Non-read op codes are ignored.
        s_en[45] = 1'b1; s_opt[45] = 2'b01; s_idx[45] = 5;
        s_en[46] = 1'b1; s_opt[46] = 2'b11; s_idx[46] = 5;
        s_en[47] = 1'b1; s_opt[47] = 2'b10; s_idx[47] = 5;
        // Back-to-back stream to indices 0..7.
        for (int i = 0; i < 8; i++) begin
            req(50 + i, IW'(i), (i % 2 == 0) ? init_tbl[i][KW-1:0] : pick_key());
        end
        // Reset drops in-flight lookups and a request made during reset.
        req(70, 1, pick_key());
        req(71, 2, pick_key());
        req(72, 3, pick_key());
        s_rst[73] = 1'b1;
        req(73, 4, pick_key());
        req(75, 5, 32'hCAFE);

        for (int n = 90; n < NCYC - 10; n++) begin
            if ($urandom_range(0, 99) < 70) begin
                s_en[n]  = 1'b1;
                s_opt[n] = ($urandom_range(0, 9) < 7) ? 2'b00 : 2'($urandom_range(1, 3));
                s_idx[n] = IW'($urandom_range(0, 15));
                s_key[n] = pick_key();
            end
            for (int j = 0; j < NW; j++) begin
                if ($urandom_range(0, 99) < 20) begin
                    snoop(n, j, IW'($urandom_range(0, 15)),
                          mk($urandom_range(0, 3) != 0, VW'($urandom), pick_key()));
                end
            end
            s_rst[n] = ($urandom_range(0, 99) == 0);
        end

        for (int n = 0; n < NCYC; n++) begin
            @(posedge clk);
            #1;
            cyc      = n;
            reset    = s_rst[n];
            en_in    = s_en[n];
            opt_in   = s_opt[n];
            index_in = s_idx[n];
            key_in   = s_key[n];
            wr_snoop_valid = s_sv[n];
            for (int j = 0; j < NW; j++) begin
                wr_snoop_index[j*IW +: IW] = s_sidx[n][j];
                wr_snoop_entry[j*DW +: DW] = s_sent[n][j];
            end

            if (s_en[n] && s_opt[n] == 2'b00 && !s_rst[n]) begin
                logic          dropped;
                logic [DW-1:0] e;
                logic          h;
                rd_q.push_back('{due: n + 1, addr: s_idx[n]});
                dropped = 1'b0;
                for (int t = n + 1; t <= n + 1 + L && t < NCYC; t++) begin
                    if (s_rst[t]) dropped = 1'b1;
                end
                if (!dropped) begin
                    e = table_at(s_idx[n], n + 1 + L);
                    h = e[KW+VW] && (e[KW-1:0] == s_key[n]);
                    out_q.push_back('{due: n + 2 + L, key: s_key[n], idx: s_idx[n],
                                      hit: h, value: h ? e[KW +: VW] : '0});
                end
            end
        end

        @(negedge clk);
        #1;
        check("out_queue_drained", 64'(out_q.size()), 64'd0);
        check("rd_queue_drained", 64'(rd_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
